uart_echo_top: RTL and testbench
================================

Name: uart_echo_top

Overview:
- Top-level UART endpoint for the AGV link.
- Receives 8N1 serial bytes on `rxd` at 115200 baud from a 100 MHz clock.
- Buffers valid bytes in a 2-entry FIFO and retransmits them unchanged, in order, on `txd` (8N1, same baud).
- Bytes with a framing error are discarded; false starts and glitches are rejected.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (=868), clocks per serial bit; localparam, integer-truncated.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rxd  input  1  asynchronous serial input; idles high.
- txd  output  1  serial output; idles high.
- Positional declaration order is mandatory: rxd, clk, reset, txd.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
- Reset values: txd=1, FIFO empty, RX and TX FSMs in IDLE, all counters 0.
- Reset asserted mid-frame aborts any RX/TX in progress; txd is 1 on the cycle after the reset edge.
- RX input synchronizer: rxd passes through a 2-flop synchronizer (reset value 1) before any use.
- RX FSM states: IDLE, START, DATA, STOP, ERR_WAIT.
  - IDLE: on synchronized rxd=0, go to START and clear the counter.
  - START: at count CLKS_PER_BIT/2 (434), resample. If 0, go to DATA with the counter reset. If 1 (glitch), return to IDLE.
  - DATA: sample every CLKS_PER_BIT clocks (mid-bit). Shift in 8 bits, LSB first, then go to STOP.
  - STOP: sample after CLKS_PER_BIT.
    - If 1: the byte is valid. Push it into the FIFO (1-cycle strobe), then go to IDLE.
    - If 0: framing error. Drop the byte and go to ERR_WAIT.
  - ERR_WAIT: stay until synchronized rxd=1, then go to IDLE.
- FIFO:
  - 2 entries x 8 bits, plain registers.
  - Push while full: the new byte is dropped; contents unchanged.
  - Simultaneous push and pop: both occur; count unchanged.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. When the FIFO is non-empty, pop the head on that cycle and enter START on the next cycle.
  - START: txd=0 for CLKS_PER_BIT clocks.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT clocks each.
  - STOP: txd=1 for CLKS_PER_BIT clocks, then IDLE.
  - Back-to-back frames: if the FIFO is non-empty at the end of STOP, the next start bit follows with at most 1 extra idle cycle.
- txd is driven directly from a register (glitch-free).
- Latency: TX start bit begins within 4 clocks of the valid RX stop-bit sample when TX is idle. That sample is at ~9.5 bit times + 2 sync clocks after the start edge.
- Throughput: sustained back-to-back RX at full baud is echoed with no loss. The 2-entry FIFO absorbs the phase offset between RX and TX.
- Unframed continuous bitstreams: resync occurs purely through the ERR_WAIT/IDLE rules above; no other recovery logic.

Decomposition:
- Package uart_pkg holds:
  - CLKS_PER_BIT (as a function of CLK_FREQ/BAUD);
  - typedef rx_state_t {IDLE, START, DATA, STOP, ERR_WAIT};
  - typedef tx_state_t {IDLE, START, DATA, STOP}.
- One sub-module, uart_rx, contains the synchronizer and RX FSM. Outputs: data[7:0], valid strobe, frame_err strobe.
- FIFO and TX FSM live in uart_echo_top.

Test Plan:
- Reset then idle (reset=1 for 434 clocks, rxd=1 for 2000 clocks) -> txd constant 1; no frame emitted.
- Single byte 0x55, 8N1, 868 clocks/bit -> txd emits start 0, bits 1,0,1,0,1,0,1,0, stop 1. Start bit begins ≤4 clocks after the RX stop-bit sample.
- Three back-to-back bytes 0xAA, 0x00, 0x33 with no idle between frames -> txd emits 0xAA, 0x00, 0x33 in order, no loss, at most 1 idle clock between frames.
- Framing error: byte 0xA5 with stop bit driven 0, then rxd=1 for 1 bit, then valid 0x11 -> only 0x11 appears on txd.
- Glitch: rxd low for 100 clocks, then high -> RX returns to IDLE; no FIFO push; txd stays 1.
- Reset mid-transmit: assert reset during TX data bit 3 of 0x78 -> txd=1 the cycle after the reset edge; FIFO empty; next valid byte 0x45 echoes correctly after reset release.

Source files
------------

// File: rtl/uart_pkg.sv
// Purpose: shared bit-timing helper and FSM encodings for the UART echo endpoint.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ = 100_000_000;
    localparam int DEFAULT_BAUD     = 115_200;

    // Clocks per serial bit, integer-truncated (100 MHz / 115200 -> 868).
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    localparam int CLKS_PER_BIT = clks_per_bit(DEFAULT_CLK_FREQ, DEFAULT_BAUD);

    typedef enum logic [2:0] {
        RX_IDLE     = 3'd0,
        RX_START    = 3'd1,
        RX_DATA     = 3'd2,
        RX_STOP     = 3'd3,
        RX_ERR_WAIT = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_rx.sv
// Purpose: 8N1 receiver with 2-flop input synchronizer, glitch and framing-error rejection.
// Latency: data/valid strobe one clock after the mid-stop-bit sample (~9.5 bits + 3 clocks after start edge).
// Backpressure: none; the valid strobe is one clock wide and must be taken or lost.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   rxd        asynchronous serial input, idles high
//   data[7:0]  received byte, held stable after valid
//   valid      one-clock strobe: data holds a well-framed byte
//   frame_err  one-clock strobe: stop bit sampled low, byte dropped
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);

    logic             rxd_meta_q, rxd_meta_d;
    logic             rxd_sync_q, rxd_sync_d;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;

    always_comb begin
        rxd_meta_d  = rxd;
        rxd_sync_d  = rxd_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (!rxd_sync_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // Half a bit in: still low means a real start bit, high means a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rxd_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                // Counter was re-based at mid start bit, so each wrap lands mid-bit.
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shreg_d   = {rxd_sync_q, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxd_sync_q) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RX_ERR_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_ERR_WAIT: begin
                // Wait for the line to return high so a low stop bit is not taken as a new start.
                if (rxd_sync_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta_q  <= 1'b1;
            rxd_sync_q  <= 1'b1;
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rxd_meta_q  <= rxd_meta_d;
            rxd_sync_q  <= rxd_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: rtl/uart_echo_top.sv
// Purpose: UART echo endpoint; well-framed RX bytes are buffered in a 2-entry FIFO and resent on txd.
// Latency: TX start bit begins 2 clocks after the RX mid-stop-bit sample when TX is idle.
// Backpressure: none on the line; a byte arriving while the FIFO is full is dropped.
//
// Ports:
//   rxd    asynchronous serial input, idles high
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   txd    serial output, idles high, driven straight from a flop
module uart_echo_top
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic rxd,
    input  logic clk,
    input  logic reset,
    output logic txd
);

    localparam int               CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int               CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);

    // ---------------- receiver ----------------
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .data     (rx_data),
        .valid    (rx_valid),
        .frame_err(rx_frame_err)
    );

    // ---------------- 2-entry FIFO ----------------
    logic [7:0] fifo_mem_q [2];
    logic [7:0] fifo_mem_d [2];
    logic       fifo_wr_ptr_q, fifo_wr_ptr_d;
    logic       fifo_rd_ptr_q, fifo_rd_ptr_d;
    logic [1:0] fifo_cnt_q, fifo_cnt_d;
    logic       fifo_full, fifo_empty;
    logic       fifo_push, fifo_pop;
    logic [7:0] fifo_head;

    assign fifo_full  = (fifo_cnt_q == 2'd2);
    assign fifo_empty = (fifo_cnt_q == 2'd0);
    assign fifo_head  = fifo_mem_q[fifo_rd_ptr_q];
    // valid and frame_err never coincide; the extra term keeps a bad frame out regardless.
    assign fifo_push  = rx_valid && !rx_frame_err && !fifo_full;

    always_comb begin
        fifo_mem_d    = fifo_mem_q;
        fifo_wr_ptr_d = fifo_wr_ptr_q;
        fifo_rd_ptr_d = fifo_rd_ptr_q;
        fifo_cnt_d    = fifo_cnt_q;

        if (fifo_push) begin
            fifo_mem_d[fifo_wr_ptr_q] = rx_data;
            fifo_wr_ptr_d             = ~fifo_wr_ptr_q;
        end
        if (fifo_pop) begin
            fifo_rd_ptr_d = ~fifo_rd_ptr_q;
        end
        case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // ---------------- transmitter ----------------
    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_idx_q, tx_bit_idx_d;
    logic [7:0]       tx_shreg_q, tx_shreg_d;
    logic             txd_q, txd_d;

    // txd_d is set on state transitions and otherwise held, so the line only
    // ever changes at bit boundaries.
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        tx_bit_idx_d = tx_bit_idx_q;
        tx_shreg_d   = tx_shreg_q;
        txd_d        = txd_q;
        fifo_pop     = 1'b0;

        case (tx_state_q)
            TX_IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_shreg_d = fifo_head;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                    txd_d      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d     = '0;
                    tx_bit_idx_d = '0;
                    tx_state_d   = TX_DATA;
                    txd_d        = tx_shreg_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_idx_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_idx_d = tx_bit_idx_q + 1'b1;
                        tx_shreg_d   = {1'b0, tx_shreg_q[7:1]};
                        txd_d        = tx_shreg_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                // One IDLE cycle follows, giving at most one extra idle clock between frames.
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                txd_d      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            fifo_wr_ptr_q <= 1'b0;
            fifo_rd_ptr_q <= 1'b0;
            fifo_cnt_q    <= '0;
            tx_state_q    <= TX_IDLE;
            tx_cnt_q      <= '0;
            tx_bit_idx_q  <= '0;
            tx_shreg_q    <= '0;
            txd_q         <= 1'b1;
        end else begin
            fifo_mem_q    <= fifo_mem_d;
            fifo_wr_ptr_q <= fifo_wr_ptr_d;
            fifo_rd_ptr_q <= fifo_rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            tx_state_q    <= tx_state_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_bit_idx_q  <= tx_bit_idx_d;
            tx_shreg_q    <= tx_shreg_d;
            txd_q         <= txd_d;
        end
    end

    assign txd = txd_q;

endmodule

// File: tb/tb_uart_echo_top.sv
// Purpose: scoreboard bench for uart_echo_top; directed frames drive rxd, a monitor decodes txd.
// Latency: expectations are queued at stimulus time and popped at each decoded TX start bit.
// Backpressure: n/a.
module tb_uart_echo_top;

    localparam int CPB  = 868;
    localparam int HALF = CPB / 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rxd   = 1'b1;
    logic txd;

    uart_echo_top dut (
        .rxd  (rxd),
        .clk  (clk),
        .reset(reset),
        .txd  (txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        bit         ignore;   // frame is cut short by reset; decode but do not compare
        bit         gap_chk;  // start-to-start spacing from previous TX frame is checked
        int         lat_ref;  // cycle rxd start was driven, or -1
    } exp_t;

    exp_t exp_q[$];

    bit mon_busy      = 1'b0;
    int mon_frames    = 0;
    int mon_start_cyc = 0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic expect_byte(input logic [7:0] b, input bit gap, input int lat, input bit ign);
        exp_t e;
        e.data    = b;
        e.ignore  = ign;
        e.gap_chk = gap;
        e.lat_ref = lat;
        exp_q.push_back(e);
    endtask

    // Called on a negedge; drives one 10-bit frame, returns on a negedge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic quiet_window(input string name, input int n);
        int low = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) low++;
        end
        check_eq(name, low, 0);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_done", {31'd0, (exp_q.size() == 0 && !mon_busy)}, 1);
    endtask

    // Monitor: decode every TX frame, compare against the scoreboard head.
    initial begin : monitor
        exp_t       e;
        bit         have;
        int         prev_start;
        logic [7:0] b;
        logic       st;
        logic       sp;
        prev_start = 0;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                mon_busy      = 1'b1;
                mon_frames++;
                mon_start_cyc = cyc;
                have          = (exp_q.size() != 0);
                if (have) e = exp_q.pop_front();
                if (have && e.lat_ref >= 0)
                    // Stop sample nominally 9.5 bits + 2 sync clocks (8248) after the start edge,
                    // +/-2 clocks of sampling phase, then at most 4 clocks to the TX start bit.
                    check_range("rx_to_tx_latency", cyc - e.lat_ref, 8248, 8254);
                if (have && e.gap_chk)
                    // 10 bits at 868 clocks, plus at most one idle clock.
                    check_range("frame_period", cyc - prev_start, 8680, 8681);
                prev_start = cyc;
                repeat (HALF) @(negedge clk);
                st = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                sp = txd;
                if (!have) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame: got byte 0x%02h expected none", b);
                end else if (!e.ignore) begin
                    check_eq("tx_start_bit", {31'd0, st}, 0);
                    check_eq("tx_byte", {24'd0, b}, {24'd0, e.data});
                    check_eq("tx_stop_bit", {31'd0, sp}, 1);
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int target;
        int n;

        // Reset then idle: reset held ~434 clocks inside a 2000-clock idle window.
        @(negedge clk);
        check_eq("txd_in_reset", {31'd0, txd}, 1);
        begin
            int low = 0;
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                if (i == 432) reset = 1'b0;
                if (txd !== 1'b1) low++;
            end
            check_eq("idle_txd_low_cycles", low, 0);
        end

        // Glitch: 100 clocks low is rejected at the half-bit resample.
        rxd = 1'b0;
        repeat (100) @(negedge clk);
        rxd = 1'b1;
        quiet_window("glitch_txd_low_cycles", 1000);

        // Single byte with latency check, then three back-to-back bytes.
        expect_byte(8'h55, 1'b0, cyc, 1'b0);
        send_frame(8'h55, 1'b1);
        expect_byte(8'hAA, 1'b1, -1, 1'b0);
        send_frame(8'hAA, 1'b1);
        expect_byte(8'h00, 1'b1, -1, 1'b0);
        send_frame(8'h00, 1'b1);
        expect_byte(8'h33, 1'b1, -1, 1'b0);
        send_frame(8'h33, 1'b1);

        // Framing error: 0xA5 with a low stop bit is dropped; one idle bit; then 0x11.
        send_frame(8'hA5, 1'b0);
        repeat (CPB) @(negedge clk);
        expect_byte(8'h11, 1'b0, -1, 1'b0);
        send_frame(8'h11, 1'b1);

        // Reset during TX data bit 3 of 0x78.
        expect_byte(8'h78, 1'b0, -1, 1'b1);
        send_frame(8'h78, 1'b1);
        n = 0;
        while (mon_frames < 6 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_eq("tx_0x78_started", {31'd0, (mon_frames >= 6)}, 1);
        target = mon_start_cyc + 4 * CPB + HALF;
        n = 0;
        while (cyc < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        @(negedge clk);
        check_eq("txd_after_reset_edge", {31'd0, txd}, 1);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        quiet_window("post_reset_txd_low_cycles", 1000);

        expect_byte(8'h45, 1'b0, -1, 1'b0);
        send_frame(8'h45, 1'b1);
        wait_drain(20000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
